// File: rtl/decode.sv
// Instruction decode stage: register file, operand read with writeback bypass,
// branch/jump resolution and the decode/execute pipeline register.
module decode (
    input  logic        clock,
    input  logic        reset,
    input  logic        ex_if_stall,
    input  logic [31:0] if_id_instruc,
    input  logic [31:0] if_id_nextpc,
    input  logic        wb_id_regwrite,
    input  logic [4:0]  wb_id_writereg,
    input  logic [31:0] wb_id_writedata,
    output logic        id_if_selpcsource,
    output logic [1:0]  id_if_selpctype,
    output logic [31:0] id_if_pcimd2ext,
    output logic [31:0] id_if_rega,
    output logic [31:0] id_if_pcindex,
    output logic [31:0] id_ex_instruc,
    output logic [31:0] id_ex_nextpc,
    output logic [31:0] id_ex_rega,
    output logic [31:0] id_ex_regb,
    output logic [31:0] id_ex_imedext,
    output logic [4:0]  id_ex_regdest,
    output logic        id_ex_regwrite,
    output logic        id_ex_memread,
    output logic        id_ex_memwrite,
    output logic        id_ex_memtoreg,
    output logic        id_ex_selimm,
    output logic        id_ex_link
);

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D, OP_XORI = 6'h0E, OP_LUI  = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23, OP_SW   = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08, FN_SYSCALL = 6'h0C;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [31:0] imm_sext, imm_zext, imm_lui;

    assign op    = if_id_instruc[31:26];
    assign rs    = if_id_instruc[25:21];
    assign rt    = if_id_instruc[20:16];
    assign rd    = if_id_instruc[15:11];
    assign imm   = if_id_instruc[15:0];
    assign funct = if_id_instruc[5:0];

    assign imm_sext = {{16{imm[15]}}, imm};
    assign imm_zext = {16'h0000, imm};
    assign imm_lui  = {imm, 16'h0000};

    logic [31:0] regs [32];
    logic [31:0] rega_val, regb_val;

    // Same-cycle writeback to a source register is forwarded so a read never sees stale data.
    assign rega_val = (rs == 5'd0) ? 32'd0 :
                      (wb_id_regwrite && wb_id_writereg == rs) ? wb_id_writedata : regs[rs];
    assign regb_val = (rt == 5'd0) ? 32'd0 :
                      (wb_id_regwrite && wb_id_writereg == rt) ? wb_id_writedata : regs[rt];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (wb_id_regwrite && wb_id_writereg != 5'd0) begin
            regs[wb_id_writereg] <= wb_id_writedata;
        end
    end

    logic        redirect, exception, bubble;
    logic [1:0]  pctype;
    logic [4:0]  regdest;
    logic [31:0] imedext;
    logic        regwrite, memread, memwrite, memtoreg, selimm, link;

    always_comb begin
        redirect  = 1'b0;
        exception = 1'b0;
        pctype    = 2'b00;
        regdest   = 5'd0;
        imedext   = imm_sext;
        regwrite  = 1'b0;
        memread   = 1'b0;
        memwrite  = 1'b0;
        memtoreg  = 1'b0;
        selimm    = 1'b0;
        link      = 1'b0;
        case (op)
            OP_RTYPE: begin
                regdest  = rd;
                regwrite = 1'b1;
                if (funct == FN_JR) begin
                    regwrite = 1'b0;
                    redirect = 1'b1;
                    pctype   = 2'b01;
                end else if (funct == FN_SYSCALL) begin
                    exception = 1'b1;
                end
            end
            OP_ADDI, OP_ADDIU, OP_SLTI: begin
                regdest  = rt;
                regwrite = 1'b1;
                selimm   = 1'b1;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                regdest  = rt;
                regwrite = 1'b1;
                selimm   = 1'b1;
                imedext  = imm_zext;
            end
            OP_LUI: begin
                regdest  = rt;
                regwrite = 1'b1;
                selimm   = 1'b1;
                imedext  = imm_lui;
            end
            OP_LW: begin
                regdest  = rt;
                regwrite = 1'b1;
                memread  = 1'b1;
                memtoreg = 1'b1;
                selimm   = 1'b1;
            end
            OP_SW: begin
                memwrite = 1'b1;
                selimm   = 1'b1;
            end
            OP_BEQ: redirect = (rega_val == regb_val);
            OP_BNE: redirect = (rega_val != regb_val);
            OP_J: begin
                redirect = 1'b1;
                pctype   = 2'b10;
            end
            OP_JAL: begin
                redirect = 1'b1;
                pctype   = 2'b10;
                regdest  = 5'd31;
                regwrite = 1'b1;
                link     = 1'b1;
            end
            default: exception = 1'b1;
        endcase
        if (exception) begin
            redirect = 1'b1;
            pctype   = 2'b11;
        end
    end

    assign bubble            = ex_if_stall | exception;
    assign id_if_selpcsource = redirect & ~ex_if_stall;
    assign id_if_selpctype   = pctype;
    assign id_if_pcimd2ext   = if_id_nextpc + {imm_sext[29:0], 2'b00};
    assign id_if_rega        = rega_val;
    assign id_if_pcindex     = {if_id_nextpc[31:28], if_id_instruc[25:0], 2'b00};

    always_ff @(posedge clock or posedge reset) begin
        if (reset || bubble) begin
            id_ex_instruc  <= '0;
            id_ex_nextpc   <= '0;
            id_ex_rega     <= '0;
            id_ex_regb     <= '0;
            id_ex_imedext  <= '0;
            id_ex_regdest  <= '0;
            id_ex_regwrite <= 1'b0;
            id_ex_memread  <= 1'b0;
            id_ex_memwrite <= 1'b0;
            id_ex_memtoreg <= 1'b0;
            id_ex_selimm   <= 1'b0;
            id_ex_link     <= 1'b0;
        end else begin
            id_ex_instruc  <= if_id_instruc;
            id_ex_nextpc   <= if_id_nextpc;
            // JAL links past the delay slot, so execute receives PC+8 as the written value.
            id_ex_rega     <= link ? if_id_nextpc + 32'd4 : rega_val;
            id_ex_regb     <= regb_val;
            id_ex_imedext  <= imedext;
            id_ex_regdest  <= regdest;
            id_ex_regwrite <= regwrite;
            id_ex_memread  <= memread;
            id_ex_memwrite <= memwrite;
            id_ex_memtoreg <= memtoreg;
            id_ex_selimm   <= selimm;
            id_ex_link     <= link;
        end
    end

endmodule

// File: tb/tb_decode.sv
// Self-checking bench for decode: directed vector table, randomized stimulus
// against an instruction-level reference model, and an async reset sequence.
module tb_decode;

    logic        clock = 1'b0;
    logic        reset;
    logic        ex_if_stall;
    logic [31:0] if_id_instruc, if_id_nextpc;
    logic        wb_id_regwrite;
    logic [4:0]  wb_id_writereg;
    logic [31:0] wb_id_writedata;
    logic        id_if_selpcsource;
    logic [1:0]  id_if_selpctype;
    logic [31:0] id_if_pcimd2ext, id_if_rega, id_if_pcindex;
    logic [31:0] id_ex_instruc, id_ex_nextpc, id_ex_rega, id_ex_regb, id_ex_imedext;
    logic [4:0]  id_ex_regdest;
    logic        id_ex_regwrite, id_ex_memread, id_ex_memwrite, id_ex_memtoreg;
    logic        id_ex_selimm, id_ex_link;

    always #5 clock = ~clock;

    decode dut (
        .clock(clock), .reset(reset), .ex_if_stall(ex_if_stall),
        .if_id_instruc(if_id_instruc), .if_id_nextpc(if_id_nextpc),
        .wb_id_regwrite(wb_id_regwrite), .wb_id_writereg(wb_id_writereg),
        .wb_id_writedata(wb_id_writedata),
        .id_if_selpcsource(id_if_selpcsource), .id_if_selpctype(id_if_selpctype),
        .id_if_pcimd2ext(id_if_pcimd2ext), .id_if_rega(id_if_rega),
        .id_if_pcindex(id_if_pcindex),
        .id_ex_instruc(id_ex_instruc), .id_ex_nextpc(id_ex_nextpc),
        .id_ex_rega(id_ex_rega), .id_ex_regb(id_ex_regb), .id_ex_imedext(id_ex_imedext),
        .id_ex_regdest(id_ex_regdest), .id_ex_regwrite(id_ex_regwrite),
        .id_ex_memread(id_ex_memread), .id_ex_memwrite(id_ex_memwrite),
        .id_ex_memtoreg(id_ex_memtoreg), .id_ex_selimm(id_ex_selimm),
        .id_ex_link(id_ex_link)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef enum {K_ALU, K_JR, K_SYS, K_IMMS, K_IMMZ, K_LUI, K_LW, K_SW,
                  K_BEQ, K_BNE, K_J, K_JAL, K_ILL} kind_t;

    typedef struct {
        logic        src;
        logic [1:0]  typ;
        logic [31:0] pcimd, pcindex, ifrega;
        logic [31:0] instruc, nextpc, rega, regb, imm;
        logic [4:0]  regdest;
        logic [5:0]  ctrl;
    } exp_t;

    logic [31:0] mregs [32];

    function automatic kind_t classify(input logic [31:0] ins);
        logic [5:0] op, fn;
        op = ins[31:26];
        fn = ins[5:0];
        case (op)
            6'h00: return (fn == 6'h08) ? K_JR : (fn == 6'h0C) ? K_SYS : K_ALU;
            6'h08, 6'h09, 6'h0A: return K_IMMS;
            6'h0C, 6'h0D, 6'h0E: return K_IMMZ;
            6'h0F: return K_LUI;
            6'h23: return K_LW;
            6'h2B: return K_SW;
            6'h04: return K_BEQ;
            6'h05: return K_BNE;
            6'h02: return K_J;
            6'h03: return K_JAL;
            default: return K_ILL;
        endcase
    endfunction

    function automatic logic [31:0] rval(input logic [4:0] r, input logic wen,
                                         input logic [4:0] wreg, input logic [31:0] wdata);
        if (r == 0) return 32'd0;
        if (wen && wreg == r) return wdata;
        return mregs[r];
    endfunction

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic wen, input logic [4:0] wreg,
                                   input logic [31:0] wdata, input logic stall);
        exp_t e;
        kind_t k;
        logic [31:0] a, b, sx;
        logic rw, mr, mw, mt, si, lk;
        k  = classify(ins);
        a  = rval(ins[25:21], wen, wreg, wdata);
        b  = rval(ins[20:16], wen, wreg, wdata);
        sx = {{16{ins[15]}}, ins[15:0]};
        e.pcimd   = pc + sx * 4;
        e.pcindex = {pc[31:28], ins[25:0], 2'b00};
        e.ifrega  = a;
        e.src = 1'b0;
        e.typ = 2'b00;
        case (k)
            K_JR:         begin e.src = 1'b1; e.typ = 2'b01; end
            K_BEQ:        e.src = (a == b);
            K_BNE:        e.src = (a != b);
            K_J, K_JAL:   begin e.src = 1'b1; e.typ = 2'b10; end
            K_SYS, K_ILL: begin e.src = 1'b1; e.typ = 2'b11; end
            default: ;
        endcase
        if (stall) e.src = 1'b0;
        rw = k inside {K_ALU, K_IMMS, K_IMMZ, K_LUI, K_LW, K_JAL};
        mr = (k == K_LW);
        mt = (k == K_LW);
        mw = (k == K_SW);
        si = k inside {K_IMMS, K_IMMZ, K_LUI, K_LW, K_SW};
        lk = (k == K_JAL);
        if (stall || k == K_SYS || k == K_ILL) begin
            e.instruc = 0; e.nextpc = 0; e.rega = 0; e.regb = 0; e.imm = 0;
            e.regdest = 0; e.ctrl = 0;
        end else begin
            e.instruc = ins;
            e.nextpc  = pc;
            e.rega    = lk ? pc + 4 : a;
            e.regb    = b;
            e.imm     = (k == K_IMMZ) ? {16'h0, ins[15:0]} :
                        (k == K_LUI)  ? {ins[15:0], 16'h0} : sx;
            e.regdest = (k == K_ALU || k == K_JR) ? ins[15:11] :
                        (k == K_JAL) ? 5'd31 :
                        (k inside {K_IMMS, K_IMMZ, K_LUI, K_LW}) ? ins[20:16] : 5'd0;
            e.ctrl    = {rw, mr, mw, mt, si, lk};
        end
        return e;
    endfunction

    logic        cap_src;
    logic [1:0]  cap_type;
    logic [31:0] cap_pcimd, cap_pcindex, cap_ifrega;

    // Entered and left 1 time unit after a rising edge.
    task automatic step(input logic [31:0] ins, input logic [31:0] pc, input logic wen,
                        input logic [4:0] wreg, input logic [31:0] wdata, input logic stall);
        exp_t e;
        if_id_instruc   = ins;
        if_id_nextpc    = pc;
        wb_id_regwrite  = wen;
        wb_id_writereg  = wreg;
        wb_id_writedata = wdata;
        ex_if_stall     = stall;
        e = model(ins, pc, wen, wreg, wdata, stall);
        #3;
        cap_src = id_if_selpcsource;
        cap_type = id_if_selpctype;
        cap_pcimd = id_if_pcimd2ext;
        cap_pcindex = id_if_pcindex;
        cap_ifrega = id_if_rega;
        chk("selpcsource", id_if_selpcsource, e.src);
        if (e.src) chk("selpctype", id_if_selpctype, e.typ);
        chk("pcimd2ext", id_if_pcimd2ext, e.pcimd);
        chk("pcindex", id_if_pcindex, e.pcindex);
        chk("id_if_rega", id_if_rega, e.ifrega);
        @(posedge clock);
        #1;
        chk("ex_instruc", id_ex_instruc, e.instruc);
        chk("ex_nextpc", id_ex_nextpc, e.nextpc);
        chk("ex_rega", id_ex_rega, e.rega);
        chk("ex_regb", id_ex_regb, e.regb);
        chk("ex_imedext", id_ex_imedext, e.imm);
        chk("ex_regdest", id_ex_regdest, e.regdest);
        chk("ex_ctrl", {id_ex_regwrite, id_ex_memread, id_ex_memwrite,
                        id_ex_memtoreg, id_ex_selimm, id_ex_link}, e.ctrl);
        if (wen && wreg != 0) mregs[wreg] = wdata;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ex_data"}, id_ex_instruc | id_ex_nextpc | id_ex_rega | id_ex_regb | id_ex_imedext, 0);
        chk({tag, "_ex_regdest"}, id_ex_regdest, 0);
        chk({tag, "_ex_ctrl"}, {id_ex_regwrite, id_ex_memread, id_ex_memwrite,
                                id_ex_memtoreg, id_ex_selimm, id_ex_link}, 0);
        chk({tag, "_if_ctrl"}, {id_if_selpcsource, id_if_selpctype}, 0);
        chk({tag, "_if_data"}, id_if_pcimd2ext | id_if_rega | id_if_pcindex, 0);
    endtask

    typedef struct {
        logic [31:0] instr, nextpc;
        logic        wen;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic        stall;
        logic        e_src;
        logic [1:0]  e_type;
        logic [1:0]  e_sel;      // 0 none, 1 pcimd2ext, 2 pcindex, 3 id_if_rega
        logic [31:0] e_addr;
        logic [4:0]  e_regdest;
        logic [31:0] e_imm;
        logic        e_regwrite;
        logic [31:0] e_rega;
    } vec_t;

    vec_t vecs [16];
    logic [5:0] ops [17] = '{6'h00, 6'h00, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                             6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03, 6'h3F, 6'h11};
    logic [5:0] fns [4] = '{6'h20, 6'h08, 6'h0C, 6'h21};

    initial begin
        vecs[0]  = '{32'h20010005, 32'h4,        0, 0, 0,            0, 0, 2'b00, 2'd0, 32'h0,        5'd1,  32'h5,        1, 32'h0};
        vecs[1]  = '{32'h00000000, 32'h8,        1, 3, 32'h7,        0, 0, 2'b00, 2'd0, 32'h0,        5'd0,  32'h0,        1, 32'h0};
        vecs[2]  = '{32'h10430003, 32'h100,      1, 2, 32'h7,        0, 1, 2'b00, 2'd1, 32'h10C,      5'd0,  32'h3,        0, 32'h7};
        vecs[3]  = '{32'h14430003, 32'h200,      0, 0, 0,            0, 0, 2'b00, 2'd1, 32'h20C,      5'd0,  32'h3,        0, 32'h7};
        vecs[4]  = '{32'h0C000010, 32'h20000008, 0, 0, 0,            0, 1, 2'b10, 2'd2, 32'h20000040, 5'd31, 32'h10,       1, 32'h2000000C};
        vecs[5]  = '{32'h00000000, 32'h204,      1, 4, 32'h400,      0, 0, 2'b00, 2'd0, 32'h0,        5'd0,  32'h0,        1, 32'h0};
        vecs[6]  = '{32'h00800008, 32'h300,      0, 0, 0,            0, 1, 2'b01, 2'd3, 32'h400,      5'd0,  32'h8,        0, 32'h400};
        vecs[7]  = '{32'hFC000000, 32'h304,      0, 0, 0,            0, 1, 2'b11, 2'd0, 32'h0,        5'd0,  32'h0,        0, 32'h0};
        vecs[8]  = '{32'h34058000, 32'h308,      0, 0, 0,            0, 0, 2'b00, 2'd0, 32'h0,        5'd5,  32'h8000,     1, 32'h0};
        vecs[9]  = '{32'h3C068000, 32'h30C,      0, 0, 0,            0, 0, 2'b00, 2'd0, 32'h0,        5'd6,  32'h80000000, 1, 32'h0};
        vecs[10] = '{32'h20078000, 32'h310,      0, 0, 0,            0, 0, 2'b00, 2'd0, 32'h0,        5'd7,  32'hFFFF8000, 1, 32'h0};
        vecs[11] = '{32'h00000000, 32'h314,      1, 0, 32'hFFFFFFFF, 0, 0, 2'b00, 2'd3, 32'h0,        5'd0,  32'h0,        1, 32'h0};
        vecs[12] = '{32'h20080001, 32'h318,      0, 0, 0,            0, 0, 2'b00, 2'd3, 32'h0,        5'd8,  32'h1,        1, 32'h0};
        vecs[13] = '{32'h8C290004, 32'h31C,      0, 0, 0,            1, 0, 2'b00, 2'd0, 32'h0,        5'd0,  32'h0,        0, 32'h0};
        vecs[14] = '{32'h0000000C, 32'h320,      0, 0, 0,            0, 1, 2'b11, 2'd0, 32'h0,        5'd0,  32'h0,        0, 32'h0};
        vecs[15] = '{32'h08000100, 32'h30000004, 0, 0, 0,            0, 1, 2'b10, 2'd2, 32'h30000400, 5'd0,  32'h100,      0, 32'h0};

        for (int i = 0; i < 32; i++) mregs[i] = 0;
        reset = 1'b1;
        ex_if_stall = 0;
        if_id_instruc = 0;
        if_id_nextpc = 0;
        wb_id_regwrite = 0;
        wb_id_writereg = 0;
        wb_id_writedata = 0;
        #2;
        chk_all_zero("reset");
        @(posedge clock);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            step(vecs[i].instr, vecs[i].nextpc, vecs[i].wen, vecs[i].wreg,
                 vecs[i].wdata, vecs[i].stall);
            chk($sformatf("vec%0d_src", i), cap_src, vecs[i].e_src);
            chk($sformatf("vec%0d_type", i), cap_type, vecs[i].e_type);
            case (vecs[i].e_sel)
                2'd1: chk($sformatf("vec%0d_pcimd2ext", i), cap_pcimd, vecs[i].e_addr);
                2'd2: chk($sformatf("vec%0d_pcindex", i), cap_pcindex, vecs[i].e_addr);
                2'd3: chk($sformatf("vec%0d_if_rega", i), cap_ifrega, vecs[i].e_addr);
                default: ;
            endcase
            chk($sformatf("vec%0d_regdest", i), id_ex_regdest, vecs[i].e_regdest);
            chk($sformatf("vec%0d_imedext", i), id_ex_imedext, vecs[i].e_imm);
            chk($sformatf("vec%0d_regwrite", i), id_ex_regwrite, vecs[i].e_regwrite);
            chk($sformatf("vec%0d_ex_rega", i), id_ex_rega, vecs[i].e_rega);
        end

        for (int n = 0; n < 400; n++) begin
            logic [31:0] ins;
            logic [5:0]  op;
            op  = ops[$urandom_range(0, 16)];
            ins = {op, 2'b00, 3'($urandom_range(0, 7)), 2'b00, 3'($urandom_range(0, 7)),
                   16'($urandom)};
            if (op == 6'h00) ins[5:0] = fns[$urandom_range(0, 3)];
            step(ins, $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 7)), 32'($urandom_range(0, 3)),
                 ($urandom_range(0, 7) == 0));
        end

        // Async reset mid-stream: registered outputs and register file clear without a clock edge.
        step(32'h00000000, 32'h40, 1, 1, 32'h1234, 0);
        step(32'h20220009, 32'h44, 0, 0, 0, 0);
        #2;
        if_id_instruc = 0;
        if_id_nextpc = 0;
        wb_id_regwrite = 0;
        reset = 1'b1;
        #1;
        chk_all_zero("async_reset");
        for (int i = 0; i < 32; i++) mregs[i] = 0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        step(32'h20220009, 32'h48, 0, 0, 0, 0);
        chk("post_reset_r1", cap_ifrega, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode.md
# decode

Second pipeline stage, between instruction fetch and execute. Decodes the 32-bit MIPS-subset instruction held in the fetch/decode register and reads operands from a 32x32 register file that it owns. Resolves branches and jumps in the same cycle and drives the PC-redirect controls back to fetch. Registers operands, immediate and control bits into the decode/execute pipeline register.

## Interface
- No parameters.
- clock  in  1  stage clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears register file and all id_ex_* outputs.
- ex_if_stall  in  1  execute stall; forces a bubble into id_ex_*.
- if_id_instruc  in  32  instruction in decode.
- if_id_nextpc  in  32  address of the instruction following if_id_instruc (PC+4).
- wb_id_regwrite  in  1  writeback enable.
- wb_id_writereg  in  5  writeback destination.
- wb_id_writedata  in  32  writeback data.
- id_if_selpcsource  out  1  redirect fetch PC (combinational).
- id_if_selpctype  out  2  00 branch, 01 register, 10 jump index, 11 exception vector 0x40.
- id_if_pcimd2ext  out  32  if_id_nextpc + (sext(imm16) << 2).
- id_if_rega  out  32  register file read of rs, bypassed.
- id_if_pcindex  out  32  {if_id_nextpc[31:28], instr[25:0], 2'b00}.
- id_ex_instruc, id_ex_nextpc, id_ex_rega, id_ex_regb, id_ex_imedext  out  32 each  registered instruction, PC+4, rs value, rt value, extended immediate.
- id_ex_regdest  out  5  registered destination register.
- id_ex_regwrite, id_ex_memread, id_ex_memwrite, id_ex_memtoreg, id_ex_selimm, id_ex_link  out  1 each  registered control bits.

## Operation
- Fields: op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], imm=[15:0], funct=[5:0].
- Register file: r0 always reads 0; writes to r0 are dropped.
  - A write at the edge is visible to a read of the same register in the same cycle: if wb_id_regwrite and wb_id_writereg==rs (or rt) and that register is nonzero, the read returns wb_id_writedata.
- Decoding by op:
  - 0x00, R-type: regdest=rd, regwrite=1.
    - funct 0x08 (JR): regwrite=0, redirect type 01.
    - funct 0x0C (SYSCALL): exception.
  - 0x08/0x09/0x0A ADDI/ADDIU/SLTI: regdest=rt, regwrite, selimm, sign-extend.
  - 0x0C/0x0D/0x0E ANDI/ORI/XORI: regdest=rt, regwrite, selimm, zero-extend.
  - 0x0F LUI: imedext={imm,16'h0}, regdest=rt, regwrite, selimm.
  - 0x23 LW: regdest=rt, regwrite, memread, memtoreg, selimm, sign-extend.
  - 0x2B SW: memwrite, selimm, sign-extend, regwrite=0.
  - 0x04 BEQ / 0x05 BNE: compare bypassed rs/rt values; if taken, redirect type 00; no register write.
  - 0x02 J: redirect type 10.
  - 0x03 JAL: redirect type 10, regdest=31, regwrite, link=1.
    - id_ex_rega = if_id_nextpc + 4, the return address past the delay slot.
  - Any other op: exception.
- Exception: selpcsource=1, type 11; id_ex_* receive a bubble.
- Bubble: every id_ex_* register is loaded with 0.
- When ex_if_stall=1: selpcsource forced to 0, and id_ex_* receive a bubble.
- Instruction 0x00000000 decodes as a write to r0, which is effectively a NOP.

## Timing
- Redirect outputs are combinational from if_id_* and the register file; fetch samples them at the next edge.
- There is exactly one branch delay slot, and it is executed.
- id_ex_* have 1-cycle latency from if_id_*.
- Register file write takes effect at the rising edge; the same-cycle bypass above covers the read in that cycle.
- Reset values: all id_ex_* = 0 and all registers = 0. With if_id_instruc=0 after fetch reset, every id_if_* control output is 0.
- Reset asserted mid-operation clears state immediately; the first edge after deassertion decodes normally.
- Load-use hazards and execute forwarding belong to downstream stages; decode does not stall on its own.

## Test plan
- Reset, then instr 0x20010005 (ADDI r1,r0,5) → id_ex_regdest=1, imedext=5, regwrite=1, selimm=1, selpcsource=0.
- Write r2=7 via writeback in the same cycle as BEQ r2,r3 with r3=7 and imm=0x0003, nextpc=0x100 → selpcsource=1, type 00, pcimd2ext=0x10C (bypass exercised).
- JAL target 0x0000010, nextpc=0x2000_0008 → type 10, pcindex=0x2000_0040, id_ex_regdest=31, id_ex_rega=0x2000_000C.
- JR r4 with r4=0x400 → type 01, id_if_rega=0x400; instr 0xFC000000 (illegal) → type 11, id_ex_* all 0.
- ORI r5,r0,0x8000 → imedext=0x0000_8000; LUI → imedext=0x8000_0000; ADDI imm 0x8000 → imedext=0xFFFF_8000.
- Write r0 with 0xFFFF_FFFF, then read r0 → 0. With ex_if_stall=1 on an LW → id_ex_* all 0 and selpcsource=0. Async reset mid-stream → outputs 0 without a clock edge.
